sha256_stream_core: RTL and testbench
=====================================

Name: sha256_stream_core

Overview:
Parametrised successor to the single-block SHA-256 accelerator. Hashes messages of any number of pre-padded 512-bit blocks by chaining the digest between blocks. Selects SHA-256 or SHA-224 per message and computes 1, 2, 4 or 8 rounds per clock. Uses ready/valid handshakes on both sides so it can sit behind a padding/DMA front end.

Parameters:
ROUNDS_PER_CYCLE, 1, compression rounds per clock; legal values 1, 2, 4, 8 (elaboration error otherwise).
RST_IV_224, 0, selects the digest-register reset value: 0 = SHA-256 IV, 1 = SHA-224 IV.

Ports:
clk  input  1  clock; all logic is rising-edge.
rst_n  input  1  asynchronous, active-low reset.
ena  input  1  global enable; when low, all state is frozen and input_ready is low.
input_data  input  512  one padded block; [511:480] = W0, big-endian words.
input_first  input  1  block is the first of a message; load the IV.
input_last  input  1  block is the last of a message; publish the digest.
input_mode_224  input  1  1 = SHA-224; sampled only when input_first=1.
input_valid  input  1  block offered.
input_ready  output  1  block accepted on a clk edge when input_valid && input_ready.
output_hash  output  256  final digest; SHA-224 gives {H0..H6, 32'h0}.
output_mode_224  output  1  mode of the presented digest.
output_valid  output  1  digest available; held until taken.
output_ready  input  1  consumer takes the digest on output_valid && output_ready.

Behaviour:
- Reset (rst_n low, async):
  - State goes to S_IDLE; output_valid=0; output_hash=0; output_mode_224=0.
  - Digest registers H0..H7 take the IV selected by RST_IV_224; round counter=0.
- States:
  - S_IDLE: input_ready = ena. On acceptance:
    - Latch the block into a 16-word schedule window.
    - Working vars a..h load the IV for the sampled mode if input_first=1, else the current H0..H7.
    - Latch last and mode; go to S_ROUNDS.
  - S_ROUNDS: each enabled edge performs ROUNDS_PER_CYCLE consecutive rounds, t..t+R-1.
    - W_t comes from the window for t<16; otherwise W_t = s1(W_t-2)+W_t-7+s0(W_t-15)+W_t-16 mod 2^32, and the window shifts.
    - K_t is read combinationally from the package constant, with no ROM latency.
    - After 64/R edges, go to S_UPDATE.
  - S_UPDATE: Hi <= Hi + working var, mod 2^32.
    - If latched last=1: drive output_hash and output_mode_224, set output_valid=1, go to S_DONE.
    - Otherwise return to S_IDLE.
  - S_DONE: hold outputs. When output_valid && output_ready, clear output_valid and go to S_IDLE.
    - output_hash keeps its value until the next publish.
- Latency: output_valid rises exactly 64/R+1 enabled edges after the accepting edge of a last block. Block-to-block throughput is 64/R+2 cycles.
- input_ready is 0 in every state except S_IDLE. There is no skid buffer; input_valid may be held indefinitely.
- ena low: no state, counter or output changes. output_valid keeps its value; a handshake does not complete while ena=0.
- input_first && input_last on the same block is a single-block message.
- input_first=0 on the first block after reset chains from the reset IV. This is legal and defined.
- input_mode_224 on non-first blocks is ignored; the message-level mode is kept.
- Reset asserted mid-message aborts it; no partial digest is ever published.
- All arithmetic is 32-bit, wrapping. Rotates are true rotates; s0/s1 shifts are logical.

Decomposition:
- Package sha256_pkg holds:
  - the state enum;
  - the 64-entry K constant array;
  - the SHA-256 and SHA-224 IVs as 256-bit localparams;
  - functions big_sigma0, big_sigma1, small_sigma0, small_sigma1, ch, maj.
- Sub-module sha256_round: one combinational round taking a..h, K_t and W_t and returning the next a..h. It is instantiated ROUNDS_PER_CYCLE times in a generate chain.

Test Plan:
- Single block "abc" (61626380, zeros, final word 00000018), first=last=1, mode 256, R=1 -> hash ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad; output_valid exactly 65 edges after acceptance.
- Same block with mode_224=1, R=4 -> 23097d22 3405d822 8642a477 bda255b3 2aadbce4 bda0b3f7 e36c9da7 00000000; latency 17 edges.
- Two-block message "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" (first, then last), R=2 -> 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1; no output_valid after block 1.
- Empty string (80000000 then zeros), then "abc" back-to-back with output_ready held low for 10 cycles -> e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855 held stable, input_ready=0 until taken, then the second digest is correct.
- ena toggling 50% random during "abc" at R=8 -> same digest; latency counts only enabled edges.
- rst_n pulsed low (asynchronously) in the middle of S_ROUNDS, then "abc" sent -> outputs zero immediately; subsequent digest correct.

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared types, constants and bit-level helper functions for the SHA-256/224 core.
package sha256_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ROUNDS = 2'd1,
        S_UPDATE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [255:0] IV_256 = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [255:0] IV_224 = {
        32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
        32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
    };

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
    endfunction

    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
    endfunction

    function automatic logic [31:0] small_sigma0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] small_sigma1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f,
                                       input logic [31:0] g);
        return (e & f) ^ (~e & g);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

endpackage

// File: rtl/sha256_round.sv
// One combinational SHA-256 compression round; state packed as {a,b,c,d,e,f,g,h}.
module sha256_round
    import sha256_pkg::*;
(
    input  logic [255:0] state_in,
    input  logic [31:0]  k,
    input  logic [31:0]  w,
    output logic [255:0] state_out
);

    logic [31:0] a, b, c, d, e, f, g, h;
    logic [31:0] t1, t2;

    assign {a, b, c, d, e, f, g, h} = state_in;
    assign t1 = h + big_sigma1(e) + ch(e, f, g) + k + w;
    assign t2 = big_sigma0(a) + maj(a, b, c);
    assign state_out = {t1 + t2, a, b, c, d + t1, e, f, g};

endmodule

// File: rtl/sha256_stream_core.sv
// Multi-block SHA-256/224 engine with ready/valid on both sides and R rounds per clock.
//
// state    | meaning
// S_IDLE   | waiting for a block; input_ready follows ena
// S_ROUNDS | R compression rounds per enabled edge, 64/R edges
// S_UPDATE | fold working vars into H; publish if the block was last
// S_DONE   | digest presented, waiting for output_ready
module sha256_stream_core
    import sha256_pkg::*;
#(
    parameter int ROUNDS_PER_CYCLE = 1,
    parameter bit RST_IV_224       = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ena,
    input  logic [511:0] input_data,
    input  logic         input_first,
    input  logic         input_last,
    input  logic         input_mode_224,
    input  logic         input_valid,
    output logic         input_ready,
    output logic [255:0] output_hash,
    output logic         output_mode_224,
    output logic         output_valid,
    input  logic         output_ready
);

    localparam int R = ROUNDS_PER_CYCLE;
    localparam logic [5:0] LAST_T = 6'(64 - R);
    localparam logic [255:0] RST_IV = RST_IV_224 ? IV_224 : IV_256;

    if (!(R == 1 || R == 2 || R == 4 || R == 8)) begin : g_bad_rounds
        $error("ROUNDS_PER_CYCLE must be 1, 2, 4 or 8");
    end

    state_t        state, state_next;
    logic [5:0]    t_cnt;
    logic [31:0]   win      [16];
    logic [31:0]   win_next [16];
    logic [255:0]  wv, h_reg, sum, round_out;
    logic          last_q, mode_q;
    logic          accept;

    assign input_ready = ena && (state == S_IDLE);
    assign accept      = input_valid && input_ready;

    // Message schedule: window holds W_t..W_t+15, extended by R freshly expanded words.
    for (genvar j = 0; j < R; j++) begin : g_w
        logic [31:0] w2, w7, nw;
        if (j < 2) begin : g_w2_win
            assign w2 = win[14 + j];
        end else begin : g_w2_new
            assign w2 = g_w[j - 2].nw;
        end
        if (j < 7) begin : g_w7_win
            assign w7 = win[9 + j];
        end else begin : g_w7_new
            assign w7 = g_w[j - 7].nw;
        end
        assign nw = small_sigma1(w2) + w7 + small_sigma0(win[1 + j]) + win[j];
    end

    for (genvar i = 0; i < 16; i++) begin : g_shift
        if (i + R < 16) begin : g_keep
            assign win_next[i] = win[i + R];
        end else begin : g_fill
            assign win_next[i] = g_w[i + R - 16].nw;
        end
    end

    // Round chain; K is indexed directly from the package table.
    for (genvar j = 0; j < R; j++) begin : g_rnd
        logic [255:0] st_in, st_out;
        if (j == 0) begin : g_head
            assign st_in = wv;
        end else begin : g_link
            assign st_in = g_rnd[j - 1].st_out;
        end
        sha256_round u_round (
            .state_in  (st_in),
            .k         (K[t_cnt + 6'(j)]),
            .w         (win[j]),
            .state_out (st_out)
        );
    end
    assign round_out = g_rnd[R - 1].st_out;

    // Word-wise wrapping add of working vars into the chaining value.
    always_comb begin
        sum = '0;
        for (int i = 0; i < 8; i++) begin
            sum[32*i +: 32] = h_reg[32*i +: 32] + wv[32*i +: 32];
        end
    end

    // State register; ena low freezes the FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else if (ena) begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (accept) state_next = S_ROUNDS;
            S_ROUNDS: if (t_cnt == LAST_T) state_next = S_UPDATE;
            S_UPDATE: state_next = last_q ? S_DONE : S_IDLE;
            S_DONE:   if (output_ready) state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // Datapath, digest chaining and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wv              <= '0;
            h_reg           <= RST_IV;
            t_cnt           <= '0;
            last_q          <= 1'b0;
            mode_q          <= RST_IV_224;
            output_hash     <= '0;
            output_mode_224 <= 1'b0;
            output_valid    <= 1'b0;
            for (int i = 0; i < 16; i++) win[i] <= '0;
        end else if (ena) begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        for (int i = 0; i < 16; i++) win[i] <= input_data[511 - 32*i -: 32];
                        if (input_first) begin
                            wv     <= input_mode_224 ? IV_224 : IV_256;
                            h_reg  <= input_mode_224 ? IV_224 : IV_256;
                            mode_q <= input_mode_224;
                        end else begin
                            wv <= h_reg;
                        end
                        last_q <= input_last;
                        t_cnt  <= '0;
                    end
                end
                S_ROUNDS: begin
                    wv    <= round_out;
                    win   <= win_next;
                    t_cnt <= t_cnt + 6'(R);
                end
                S_UPDATE: begin
                    h_reg <= sum;
                    if (last_q) begin
                        output_hash     <= mode_q ? {sum[255:32], 32'h0} : sum;
                        output_mode_224 <= mode_q;
                        output_valid    <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (output_ready) output_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_stream_core.sv
// Bench: four cores at R = 1, 2, 4, 8 sharing stimulus; only the selected one sees valid/ready.
module tb_sha256_stream_core;

    localparam logic [255:0] ABC256 = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [255:0] ABC224 = 256'h23097d22_3405d822_8642a477_bda255b3_2aadbce4_bda0b3f7_e36c9da7_00000000;
    localparam logic [255:0] TWO256 = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;
    localparam logic [255:0] EMP256 = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         ena;
    logic [511:0] data;
    logic         first, last, mode;
    logic         in_valid, out_ready;
    int           sel;
    logic         rand_ena;

    logic [3:0]   ready_v, valid_v, mode_v;
    logic [255:0] hash_v [4];

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        sha256_stream_core #(.ROUNDS_PER_CYCLE(1 << g), .RST_IV_224(1'b0)) dut (
            .clk             (clk),
            .rst_n           (rst_n),
            .ena             (ena),
            .input_data      (data),
            .input_first     (first),
            .input_last      (last),
            .input_mode_224  (mode),
            .input_valid     (in_valid && (sel == g)),
            .input_ready     (ready_v[g]),
            .output_hash     (hash_v[g]),
            .output_mode_224 (mode_v[g]),
            .output_valid    (valid_v[g]),
            .output_ready    (out_ready && (sel == g))
        );
    end

    typedef struct {
        int           sel;
        int           msg;
        logic         mode;
        logic [255:0] exp;
        int           lat;
    } vec_t;

    vec_t vecs [7];
    logic [511:0] blk_abc, blk_empty, blk_b1, blk_b2;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(negedge clk);
        if (rand_ena) ena = 1'($urandom_range(0, 1));
    endtask

    // Offer a block and return once the accepting edge has passed; n = ticks spent waiting.
    task automatic send_block(input int s, input logic [511:0] d, input logic f,
                              input logic l, input logic m, output int n);
        sel = s; data = d; first = f; last = l; mode = m; in_valid = 1'b1;
        n = 0;
        while (!ready_v[s] && n < 2000) begin
            tick();
            n++;
        end
        if (n >= 2000) check("send_timeout", 256'(n), 256'd0);
        tick();
        in_valid = 1'b0;
    endtask

    // Count enabled edges until output_valid rises.
    task automatic wait_valid(input int s, output int lat);
        int n;
        logic e;
        lat = 0;
        n = 0;
        while (n < 2000) begin
            e = ena;
            tick();
            if (e) lat++;
            n++;
            if (valid_v[s]) break;
        end
        if (!valid_v[s]) check("valid_timeout", 256'(valid_v[s]), 256'd1);
    endtask

    task automatic take(input int s);
        int n;
        logic e;
        sel = s;
        out_ready = 1'b1;
        n = 0;
        while (n < 2000) begin
            e = ena;
            tick();
            n++;
            if (e) break;
        end
        out_ready = 1'b0;
        check("valid_cleared", 256'(valid_v[s]), 256'd0);
    endtask

    initial begin
        int n, lat, s;
        logic stable, seen;

        blk_abc   = {32'h61626380, {14{32'h0}}, 32'h00000018};
        blk_empty = {32'h80000000, 480'h0};
        blk_b1    = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                     32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                     32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                     32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
        blk_b2    = {448'h0, 32'h00000000, 32'h000001c0};

        vecs[0] = '{0, 0, 1'b0, ABC256, 65};
        vecs[1] = '{2, 0, 1'b1, ABC224, 17};
        vecs[2] = '{1, 0, 1'b0, ABC256, 33};
        vecs[3] = '{3, 0, 1'b1, ABC224, 9};
        vecs[4] = '{3, 1, 1'b0, EMP256, 9};
        vecs[5] = '{0, 0, 1'b1, ABC224, 65};
        vecs[6] = '{2, 1, 1'b0, EMP256, 17};

        rst_n = 1'b0; ena = 1'b1; data = '0; first = 1'b0; last = 1'b0; mode = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; sel = 0; rand_ena = 1'b0;
        #23 rst_n = 1'b1;
        tick();

        for (int i = 0; i < 4; i++) begin
            check("rst_hash", hash_v[i], 256'd0);
            check("rst_valid", 256'(valid_v[i]), 256'd0);
            check("rst_mode", 256'(mode_v[i]), 256'd0);
            check("rst_ready", 256'(ready_v[i]), 256'd1);
        end

        for (int i = 0; i < 7; i++) begin
            send_block(vecs[i].sel, (vecs[i].msg == 0) ? blk_abc : blk_empty,
                       1'b1, 1'b1, vecs[i].mode, n);
            wait_valid(vecs[i].sel, lat);
            check("vec_hash", hash_v[vecs[i].sel], vecs[i].exp);
            check("vec_mode", 256'(mode_v[vecs[i].sel]), 256'(vecs[i].mode));
            check("vec_latency", 256'(lat), 256'(vecs[i].lat));
            take(vecs[i].sel);
        end

        // Two-block message at R=2; mode on the second block must be ignored.
        send_block(1, blk_b1, 1'b1, 1'b0, 1'b0, n);
        seen = 1'b0;
        sel = 1; data = blk_b2; first = 1'b0; last = 1'b1; mode = 1'b1; in_valid = 1'b1;
        n = 0;
        while (!ready_v[1] && n < 2000) begin
            tick();
            n++;
            if (valid_v[1]) seen = 1'b1;
        end
        check("b2b_wait", 256'(n), 256'd33);
        check("two_no_early_valid", 256'(seen), 256'd0);
        tick();
        in_valid = 1'b0;
        wait_valid(1, lat);
        check("two_hash", hash_v[1], TWO256);
        check("two_mode", 256'(mode_v[1]), 256'd0);
        check("two_latency", 256'(lat), 256'd33);
        take(1);

        // Empty then abc with output backpressure at R=4.
        send_block(2, blk_empty, 1'b1, 1'b1, 1'b0, n);
        wait_valid(2, lat);
        check("bp_empty_hash", hash_v[2], EMP256);
        data = blk_abc; first = 1'b1; last = 1'b1; mode = 1'b0; in_valid = 1'b1;
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (ready_v[2] !== 1'b0 || valid_v[2] !== 1'b1 || hash_v[2] !== EMP256) stable = 1'b0;
        end
        check("bp_hold", 256'(stable), 256'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_taken_valid", 256'(valid_v[2]), 256'd0);
        check("bp_taken_ready", 256'(ready_v[2]), 256'd1);
        check("bp_hash_kept", hash_v[2], EMP256);
        tick();
        in_valid = 1'b0;
        wait_valid(2, lat);
        check("bp_abc_hash", hash_v[2], ABC256);
        check("bp_abc_latency", 256'(lat), 256'd17);
        take(2);

        // Random ena at R=8; latency counts enabled edges only.
        rand_ena = 1'b1;
        send_block(3, blk_abc, 1'b1, 1'b1, 1'b0, n);
        wait_valid(3, lat);
        check("ena_hash", hash_v[3], ABC256);
        check("ena_latency", 256'(lat), 256'd9);
        take(3);
        rand_ena = 1'b0;
        ena = 1'b1;

        // Async reset mid-rounds at R=1, then abc chained from the reset IV (first=0).
        s = 0;
        send_block(s, blk_abc, 1'b1, 1'b1, 1'b0, n);
        for (int i = 0; i < 20; i++) tick();
        #2 rst_n = 1'b0;
        #1;
        check("arst_hash", hash_v[s], 256'd0);
        check("arst_valid", 256'(valid_v[s]), 256'd0);
        check("arst_ready", 256'(ready_v[s]), 256'd1);
        #1 rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 70; i++) begin
            tick();
            if (valid_v[s]) seen = 1'b1;
        end
        check("arst_no_publish", 256'(seen), 256'd0);
        send_block(s, blk_abc, 1'b0, 1'b1, 1'b0, n);
        wait_valid(s, lat);
        check("arst_chain_hash", hash_v[s], ABC256);
        check("arst_chain_latency", 256'(lat), 256'd65);
        take(s);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
